// File: rtl/sm_fixed_addsub_pipe.sv
// Two-stage pipelined sign-magnitude fixed-point adder/subtractor with valid/ready handshake.
// Define SM_ADDSUB_SATURATE_EN to clamp overflowed magnitudes to all ones instead of wrapping.
module sm_fixed_addsub_pipe #(
    parameter int  INT_BITS  = 21,
    parameter int  FRAC_BITS = 10,
    localparam int W         = 1 + INT_BITS + FRAC_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Z,
    output logic         ovf,
    output logic         ovf_sticky,
    input  logic         clr_ovf
);
    localparam int M = W - 1;

    logic         s1_valid_reg;
    logic [M-1:0] s1_big_reg;
    logic [M-1:0] s1_small_reg;
    logic         s1_add_reg;
    logic         s1_sign_reg;

    logic         out_valid_reg;
    logic [W-1:0] z_reg;
    logic         ovf_reg;
    logic         ovf_sticky_reg;

    logic         out_adv;
    logic         sign_a;
    logic         sign_b_eff;
    logic [M-1:0] mag_a;
    logic [M-1:0] mag_b;
    logic         same_sign;
    logic         a_is_big;
    logic [M-1:0] big_next;
    logic [M-1:0] small_next;
    logic         sign_next;

    logic [M:0]   sum_full;
    logic [M-1:0] diff;
    logic         ovf_next;
    logic [M-1:0] mag_next;
    logic [W-1:0] z_next;

    // Stage 2 can take a new word when it is empty or its word leaves this cycle.
    assign out_adv  = !out_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || out_adv;

    assign sign_a     = a[W-1];
    assign sign_b_eff = b[W-1] ^ op;
    assign mag_a      = a[M-1:0];
    assign mag_b      = b[M-1:0];
    assign same_sign  = (sign_a == sign_b_eff);
    assign a_is_big   = same_sign || (mag_a >= mag_b);

    always_comb begin
        big_next   = mag_b;
        small_next = mag_a;
        sign_next  = sign_b_eff;
        if (a_is_big) begin
            big_next   = mag_a;
            small_next = mag_b;
            sign_next  = sign_a;
        end
    end

    assign sum_full = {1'b0, s1_big_reg} + {1'b0, s1_small_reg};
    assign diff     = s1_big_reg - s1_small_reg;
    assign ovf_next = s1_add_reg & sum_full[M];

    always_comb begin
        mag_next = s1_add_reg ? sum_full[M-1:0] : diff;
`ifdef SM_ADDSUB_SATURATE_EN
        if (ovf_next) begin
            mag_next = '1;
        end
`endif
        // A zero magnitude is always reported as +0, whatever the operand signs were.
        z_next = {s1_sign_reg && (mag_next != '0), mag_next};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_big_reg     <= '0;
            s1_small_reg   <= '0;
            s1_add_reg     <= 1'b0;
            s1_sign_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
            z_reg          <= '0;
            ovf_reg        <= 1'b0;
            ovf_sticky_reg <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_big_reg   <= big_next;
                    s1_small_reg <= small_next;
                    s1_add_reg   <= same_sign;
                    s1_sign_reg  <= sign_next;
                end
            end
            if (out_adv) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    z_reg   <= z_next;
                    ovf_reg <= ovf_next;
                end
            end
            // Setting takes priority over a simultaneous clear.
            if (out_valid_reg && out_ready && ovf_reg) begin
                ovf_sticky_reg <= 1'b1;
            end else if (clr_ovf) begin
                ovf_sticky_reg <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign Z          = z_reg;
    assign ovf        = ovf_reg;
    assign ovf_sticky = ovf_sticky_reg;

endmodule

// File: tb/tb_sm_fixed_addsub_pipe.sv
// Self-checking bench for sm_fixed_addsub_pipe: directed vectors plus randomized traffic
// checked against a signed-integer reference model and an in-order expectation queue.
module tb_sm_fixed_addsub_pipe;
    localparam int W = 32;
    localparam int M = W - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         op = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] Z;
    logic         ovf;
    logic         ovf_sticky;
    logic         clr_ovf = 1'b0;

    sm_fixed_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .Z(Z), .ovf(ovf), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] z;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           n_out = 0;
    logic         sticky_m = 1'b0;
    logic         chk_lat = 1'b0;
    logic         use_lit = 1'b0;
    logic [W-1:0] lit_z = '0;
    logic         lit_ovf = 1'b0;
    logic         s_in_ready, s_out_valid;
    logic [W-1:0] s_z;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret words as signed integers, do plain arithmetic, re-encode.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        longint va, vb, r, mag, lim;
        logic ov, sg;
        logic [M-1:0] zm;
        lim = longint'(1) << M;
        va  = x[W-1] ? -longint'(x[M-1:0]) : longint'(x[M-1:0]);
        vb  = y[W-1] ? -longint'(y[M-1:0]) : longint'(y[M-1:0]);
        r   = o ? (va - vb) : (va + vb);
        mag = (r < 0) ? -r : r;
        ov  = (mag >= lim);
`ifdef SM_ADDSUB_SATURATE_EN
        if (ov) mag = lim - 1;
`endif
        zm = M'(mag % lim);
        sg = (r < 0) && (zm != '0);
        return {ov, sg, zm};
    endfunction

    task automatic tick();
        exp_t e;
        logic ix, ox, set;
        logic [W:0] m;
        set = 1'b0;
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_z         = Z;
        ix = in_valid && in_ready;
        ox = out_valid && out_ready;
        if (rst) begin
            q.delete();
            sticky_m = 1'b0;
        end else begin
            if (ox) begin
                n_out++;
                check("out_pending", {63'd0, q.size() != 0}, 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("z", Z, e.z);
                    check("ovf", ovf, e.ovf);
                    if (chk_lat) check("latency", cyc - e.cyc, 2);
                    set = e.ovf;
                end
            end
            if (ix) begin
                m = model(a, b, op);
                e.z   = use_lit ? lit_z : m[W-1:0];
                e.ovf = use_lit ? lit_ovf : m[W];
                e.cyc = cyc;
                q.push_back(e);
                $display("txn %0d: a=%08h b=%08h op=%0d -> expect Z=%08h ovf=%0d", cyc, a, b, op, e.z, e.ovf);
            end
            if (set) sticky_m = 1'b1;
            else if (clr_ovf) sticky_m = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (!rst) check("sticky", ovf_sticky, sticky_m);
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                        input logic [W-1:0] ez, input logic eo);
        in_valid = 1'b1; a = x; b = y; op = o;
        use_lit = 1'b1; lit_z = ez; lit_ovf = eo;
        tick();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("drain_empty", q.size(), 0);
        tick();
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[M-1:0] = '0;
            1: w[M-1:M-3] = 3'b111;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        int n0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_z", Z, 0);
        check("rst_ovf", ovf, 0);
        check("rst_sticky", ovf_sticky, 0);
        check("rst_in_ready", in_ready, 1);

        // Streaming directed vectors, one per cycle, no backpressure.
        chk_lat = 1'b1; out_ready = 1'b1;
        send(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0);
        send(32'h00000200, 32'h00000400, 1'b0, 32'h00000600, 1'b0);
        send(32'h00000508, 32'h00989680, 1'b0, 32'h00989B88, 1'b0);
        send(32'hB2EF5901, 32'h35905D0E, 1'b0, 32'h02A1040D, 1'b0);
        send(32'h14C7DBC7, 32'h8DFAE342, 1'b0, 32'h06CCF885, 1'b0);
        send(32'h94C7DBC7, 32'h0DFAE342, 1'b0, 32'h86CCF885, 1'b0);
        drain();

`ifdef SM_ADDSUB_SATURATE_EN
        send(32'h28D99763, 32'h5E6D23E4, 1'b0, 32'h7FFFFFFF, 1'b1);
        send(32'hA8D99763, 32'hDE6D23E4, 1'b0, 32'hFFFFFFFF, 1'b1);
`else
        send(32'h28D99763, 32'h5E6D23E4, 1'b0, 32'h0746BB47, 1'b1);
        send(32'hA8D99763, 32'hDE6D23E4, 1'b0, 32'h8746BB47, 1'b1);
`endif
        drain();
        check("sticky_set", ovf_sticky, 1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("sticky_clr", ovf_sticky, 0);

        send(32'h00000400, 32'h00000400, 1'b1, 32'h00000000, 1'b0);
        send(32'h00000200, 32'h00000400, 1'b1, 32'h80000200, 1'b0);
        send(32'h80000400, 32'h00000400, 1'b1, 32'h80000800, 1'b0);
        drain();

        // Backpressure: third pair must wait while the first result is held.
        chk_lat = 1'b0; use_lit = 1'b0; out_ready = 1'b0; n0 = n_out;
        in_valid = 1'b1; a = rand_word(); b = rand_word(); op = 1'($urandom);
        tick();
        check("bp_accept1", s_in_ready, 1);
        a = rand_word(); b = rand_word(); op = 1'($urandom);
        tick();
        check("bp_accept2", s_in_ready, 1);
        a = rand_word(); b = rand_word(); op = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready", s_in_ready, 0);
            check("bp_out_valid", s_out_valid, 1);
            check("bp_z_hold", s_z, q[0].z);
        end
        out_ready = 1'b1;
        tick();
        drain();
        check("bp_count", n_out - n0, 3);

        // Reset with two pairs in flight, then a fresh pair.
        in_valid = 1'b1; a = 32'h28D99763; b = 32'h5E6D23E4; op = 1'b0; tick();
        a = 32'h00000001; b = 32'h00000002; tick();
        in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_z", Z, 0);
        check("mid_rst_sticky", ovf_sticky, 0);
        check("mid_rst_in_ready", in_ready, 1);
        chk_lat = 1'b1;
        send(32'h00000508, 32'h00989680, 1'b0, 32'h00989B88, 1'b0);
        drain();

        // Randomized traffic with random stalls and clears.
        chk_lat = 1'b0; use_lit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            clr_ovf   = ($urandom_range(0, 9) == 0);
            a  = rand_word();
            b  = ($urandom_range(0, 7) == 0) ? {1'($urandom), a[M-1:0]} : rand_word();
            op = 1'($urandom);
            tick();
        end
        clr_ovf = 1'b0; out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
